// File: rtl/uart0_pkg.sv
// Shared types and constants for the UART0 transmit arbiter and its serializer.
package uart0_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   localparam logic [1:0] OWN_A = 2'b01;
   localparam logic [1:0] OWN_B = 2'b10;

   localparam int unsigned CLKS_PER_BIT_DEF  = 1736;
   localparam int unsigned LOCK_IDLE_CYC_DEF = 27776;

endpackage

// File: rtl/uart0_tx_ser.sv
// 8N1 serializer: latches tx_byte on start, sends start/8 data LSB-first/stop.
module uart0_tx_ser
   import uart0_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic       sys_clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] tx_byte,
   output logic       done_c,
   output logic       txd
);

   localparam int unsigned     CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]   CNT_MAX = CW'(CLKS_PER_BIT - 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            txd_q, txd_d;
   logic            last_tick;

   assign last_tick = (cnt_q == CNT_MAX);
   assign done_c    = (state_q == STOP) && last_tick;
   assign txd       = txd_q;

   // txd is derived from the next state so the line changes on the same edge as the state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      txd_d   = 1'b1;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = START;
               cnt_d   = '0;
               idx_d   = '0;
               shreg_d = tx_byte;
            end
         end
         START: begin
            if (last_tick) begin
               state_d = DATA;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (last_tick) begin
               cnt_d   = '0;
               shreg_d = shreg_q >> 1;
               if (idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOP: begin
            if (last_tick) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d == START) begin
         txd_d = 1'b0;
      end else if (state_d == DATA) begin
         txd_d = shreg_d[0];
      end
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         txd_q   <= txd_d;
      end
   end

endmodule

// File: rtl/uart0_tx_arbiter.sv
// Two-requester UART0 transmit arbiter: round-robin with per-message lock and idle lock release.
module uart0_tx_arbiter
   import uart0_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT  = CLKS_PER_BIT_DEF,
   parameter int unsigned LOCK_IDLE_CYC = LOCK_IDLE_CYC_DEF
) (
   input  logic       sys_clk,
   input  logic       reset,
   input  logic       a_valid,
   input  logic       a_last,
   input  logic [7:0] a_data,
   output logic       a_ready,
   input  logic       b_valid,
   input  logic       b_last,
   input  logic [7:0] b_data,
   output logic       b_ready,
   output logic       txd,
   output logic [1:0] grant,
   output logic       busy
);

   localparam int unsigned   IW       = $clog2(LOCK_IDLE_CYC + 1);
   localparam logic [IW-1:0] IDLE_MAX = IW'(LOCK_IDLE_CYC - 1);

   logic          busy_q, busy_d;
   logic [1:0]    grant_q, grant_d;
   logic [1:0]    last_q, last_d;
   logic          lock_q, lock_d;
   logic [1:0]    lock_own_q, lock_own_d;
   logic [IW-1:0] idle_cnt_q, idle_cnt_d;
   logic [1:0]    win;
   logic          accept;
   logic          sel_last;
   logic [7:0]    sel_data;
   logic          owner_valid;
   logic          ser_done;

   assign a_ready = win[0];
   assign b_ready = win[1];
   assign grant   = grant_q;
   assign busy    = busy_q;

   // Winner selection: only in IDLE; lock owner exclusive, otherwise round-robin
   always_comb begin
      win = 2'b00;
      if (!busy_q && !reset) begin
         if (lock_q) begin
            if (lock_own_q == OWN_A) begin
               win = a_valid ? OWN_A : 2'b00;
            end else begin
               win = b_valid ? OWN_B : 2'b00;
            end
         end else if (a_valid && b_valid) begin
            win = (last_q == OWN_A) ? OWN_B : OWN_A;
         end else if (a_valid) begin
            win = OWN_A;
         end else if (b_valid) begin
            win = OWN_B;
         end
      end
   end

   assign accept      = |win;
   assign sel_data    = win[1] ? b_data : a_data;
   assign sel_last    = win[1] ? b_last : a_last;
   assign owner_valid = (lock_own_q == OWN_A) ? a_valid : b_valid;

   always_comb begin
      busy_d     = busy_q;
      grant_d    = grant_q;
      last_d     = last_q;
      lock_d     = lock_q;
      lock_own_d = lock_own_q;
      idle_cnt_d = idle_cnt_q;
      if (accept) begin
         busy_d     = 1'b1;
         grant_d    = win;
         last_d     = win;
         lock_d     = !sel_last;
         idle_cnt_d = '0;
         if (!sel_last) begin
            lock_own_d = win;
         end
      end else if (ser_done) begin
         busy_d = 1'b0;
      end
      // Stalled lock owner: count idle cycles and drop the lock at the limit
      if (!accept) begin
         if (busy_q || !lock_q || owner_valid) begin
            idle_cnt_d = '0;
         end else if (idle_cnt_q == IDLE_MAX) begin
            lock_d     = 1'b0;
            idle_cnt_d = '0;
         end else begin
            idle_cnt_d = idle_cnt_q + IW'(1);
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         busy_q     <= 1'b0;
         grant_q    <= 2'b00;
         last_q     <= OWN_B;
         lock_q     <= 1'b0;
         lock_own_q <= OWN_A;
         idle_cnt_q <= '0;
      end else begin
         busy_q     <= busy_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         lock_q     <= lock_d;
         lock_own_q <= lock_own_d;
         idle_cnt_q <= idle_cnt_d;
      end
   end

   uart0_tx_ser #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_ser (
      .sys_clk (sys_clk),
      .reset   (reset),
      .start   (accept),
      .tx_byte (sel_data),
      .done_c  (ser_done),
      .txd     (txd)
   );

endmodule

// File: tb/tb_uart0_tx_arbiter.sv
// Scenario bench for uart0_tx_arbiter; a txd frame decoder checks bytes against an expected queue.
module tb_uart0_tx_arbiter;
   import uart0_pkg::*;

   logic       sys_clk = 1'b0;
   logic       reset   = 1'b1;
   logic       a_valid = 1'b0, a_last = 1'b0, b_valid = 1'b0, b_last = 1'b0;
   logic [7:0] a_data  = 8'h00, b_data = 8'h00;
   logic       a_ready, b_ready, txd, busy;
   logic [1:0] grant;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   logic [7:0] exp_q[$];

   uart0_tx_arbiter #(.CLKS_PER_BIT(4), .LOCK_IDLE_CYC(20)) dut (
      .sys_clk(sys_clk), .reset(reset),
      .a_valid(a_valid), .a_last(a_last), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_last(b_last), .b_data(b_data), .b_ready(b_ready),
      .txd(txd), .grant(grant), .busy(busy)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   // Frame decoder: samples 4-cycle bits mid-bit, checks framing, pops the expected byte
   bit         mon_active = 1'b0;
   int         mon_cnt    = 0;
   logic [7:0] mon_byte   = 8'h00;
   logic [7:0] mon_exp;
   always @(negedge sys_clk) begin
      if (reset) begin
         mon_active = 1'b0;
      end else if (!mon_active) begin
         if (txd === 1'b0) begin
            mon_active = 1'b1;
            mon_cnt    = 0;
         end
      end else begin
         mon_cnt++;
         if (mon_cnt == 2) begin
            n_checks++;
            if (txd !== 1'b0) begin n_fail++; $display("FAIL start_bit: txd=%b required 0", txd); end
         end
         if (mon_cnt >= 4 && mon_cnt < 36 && (mon_cnt % 4) == 2) mon_byte[3'((mon_cnt - 4) / 4)] = txd;
         if (mon_cnt >= 36) begin
            n_checks++;
            if (txd !== 1'b1) begin n_fail++; $display("FAIL stop_bit: txd=%b required 1 at cycle %0d of frame", txd, mon_cnt); end
         end
         if (mon_cnt == 39) begin
            mon_active = 1'b0;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL frame_byte: got 0x%02h, required no frame", mon_byte);
            end else begin
               mon_exp = exp_q.pop_front();
               if (mon_byte !== mon_exp) begin n_fail++; $display("FAIL frame_byte: got 0x%02h required 0x%02h", mon_byte, mon_exp); end
            end
         end
      end
   end

   task automatic wait_ready(input bit is_b, input int budget, output int t);
      t = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge sys_clk);
         if ((is_b ? b_ready : a_ready) === 1'b1) begin t = cyc; return; end
      end
   endtask

   task automatic wait_idle(input int budget, output int t);
      t = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge sys_clk);
         if (busy === 1'b0) begin t = cyc; return; end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; a_valid = 1'b1; a_data = 8'h77; a_last = 1'b1; b_valid = 1'b1;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b required 1", txd); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
      n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b required 00", grant); end
      n_checks++; if ({a_ready, b_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b required 00", {a_ready, b_ready}); end
      @(posedge sys_clk); #1;
      reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic test_single();
      int t;
      logic [7:0] v;
      logic exp_txd;
      v = 8'h55;
      @(posedge sys_clk); #1;
      a_valid = 1'b1; a_data = 8'h55; a_last = 1'b1; exp_q.push_back(8'h55);
      wait_ready(1'b0, 5, t);
      n_checks++; if (t < 0) begin n_fail++; $display("FAIL single_ready: a_ready not seen, required within 5 cycles"); end
      @(posedge sys_clk); #1;
      for (int k = 0; k <= 40; k++) begin
         @(negedge sys_clk);
         if (k == 0) begin
            n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_pulse: got %b required 0", a_ready); end
            a_valid = 1'b0;
         end
         exp_txd = (k < 4) ? 1'b0 : (k < 36) ? v[3'((k - 4) / 4)] : 1'b1;
         n_checks++;
         if ({busy, txd} !== {(k < 40), exp_txd}) begin
            n_fail++; $display("FAIL single_wave k=%0d: busy,txd=%b%b required %b%b", k, busy, txd, (k < 40), exp_txd);
         end
      end
      n_checks++; if (grant !== OWN_A) begin n_fail++; $display("FAIL single_grant: got %b required 01", grant); end
   endtask

   task automatic test_tie();
      int t;
      @(posedge sys_clk); #1; reset = 1'b1;
      @(posedge sys_clk); #1; reset = 1'b0;
      a_valid = 1'b1; a_data = 8'hA1; a_last = 1'b1;
      b_valid = 1'b1; b_data = 8'hB2; b_last = 1'b1;
      exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
      wait_ready(1'b0, 5, t);
      n_checks++; if (t < 0 || b_ready !== 1'b0) begin n_fail++; $display("FAIL tie_a_first: a_ready=%b b_ready=%b required 1,0", a_ready, b_ready); end
      @(posedge sys_clk); #1; a_valid = 1'b0;
      @(negedge sys_clk);
      n_checks++; if (grant !== OWN_A) begin n_fail++; $display("FAIL tie_grant_a: got %b required 01", grant); end
      wait_ready(1'b1, 60, t);
      n_checks++; if (t < 0) begin n_fail++; $display("FAIL tie_b_second: b_ready not seen, required within 60 cycles"); end
      @(posedge sys_clk); #1; b_valid = 1'b0;
      @(negedge sys_clk);
      n_checks++; if (grant !== OWN_B) begin n_fail++; $display("FAIL tie_grant_b: got %b required 10", grant); end
      wait_idle(60, t);
   endtask

   task automatic test_lock();
      int t;
      bit got_a, seen_b;
      @(posedge sys_clk); #1;
      a_valid = 1'b1; a_data = 8'h10; a_last = 1'b0;
      b_valid = 1'b1; b_data = 8'hBB; b_last = 1'b1;
      exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'hBB);
      wait_ready(1'b0, 5, t);
      n_checks++; if (t < 0) begin n_fail++; $display("FAIL lock_first: a_ready not seen, required within 5 cycles"); end
      @(posedge sys_clk); #1; a_data = 8'h11; a_last = 1'b1;
      got_a = 1'b0; seen_b = 1'b0;
      for (int i = 0; i < 60 && !got_a; i++) begin
         @(negedge sys_clk);
         if (b_ready === 1'b1) seen_b = 1'b1;
         if (a_ready === 1'b1) got_a = 1'b1;
      end
      n_checks++; if (seen_b !== 1'b0) begin n_fail++; $display("FAIL lock_b_blocked: b_ready seen=%b required 0", seen_b); end
      n_checks++; if (got_a !== 1'b1) begin n_fail++; $display("FAIL lock_a_second: a_ready seen=%b required 1", got_a); end
      @(posedge sys_clk); #1; a_valid = 1'b0;
      wait_ready(1'b1, 60, t);
      n_checks++; if (t < 0) begin n_fail++; $display("FAIL lock_b_after: b_ready not seen, required within 60 cycles"); end
      @(posedge sys_clk); #1; b_valid = 1'b0;
      wait_idle(60, t);
   endtask

   task automatic test_lock_timeout();
      int t, t_idle, t_b;
      @(posedge sys_clk); #1;
      a_valid = 1'b1; a_data = 8'h20; a_last = 1'b0;
      exp_q.push_back(8'h20); exp_q.push_back(8'hC3);
      wait_ready(1'b0, 5, t);
      n_checks++; if (t < 0) begin n_fail++; $display("FAIL timeout_a: a_ready not seen, required within 5 cycles"); end
      @(posedge sys_clk); #1;
      a_valid = 1'b0; b_valid = 1'b1; b_data = 8'hC3; b_last = 1'b1;
      wait_idle(60, t_idle);
      wait_ready(1'b1, 40, t_b);
      n_checks++;
      if (t_idle < 0 || t_b < 0 || (t_b - t_idle) != 20) begin
         n_fail++; $display("FAIL lock_timeout: b accepted %0d idle cycles after frame end (idle=%0d b=%0d), required 20", t_b - t_idle, t_idle, t_b);
      end
      @(posedge sys_clk); #1; b_valid = 1'b0;
      wait_idle(60, t);
   endtask

   task automatic test_reset_mid();
      int t;
      bit reissued;
      @(posedge sys_clk); #1;
      a_valid = 1'b1; a_data = 8'hFF; a_last = 1'b1;
      wait_ready(1'b0, 5, t);
      n_checks++; if (t < 0) begin n_fail++; $display("FAIL midreset_ready: a_ready not seen, required within 5 cycles"); end
      @(posedge sys_clk); #1; a_valid = 1'b0;
      repeat (18) @(negedge sys_clk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_inflight: busy=%b required 1", busy); end
      reset = 1'b1;
      @(negedge sys_clk);
      n_checks++; if ({txd, busy} !== 2'b10) begin n_fail++; $display("FAIL midreset_abort: txd,busy=%b%b required 10", txd, busy); end
      @(posedge sys_clk); #1; reset = 1'b0;
      reissued = 1'b0;
      repeat (5) begin @(negedge sys_clk); if (a_ready === 1'b1 || busy === 1'b1) reissued = 1'b1; end
      n_checks++; if (reissued !== 1'b0) begin n_fail++; $display("FAIL midreset_no_reissue: activity=%b required 0", reissued); end
      @(posedge sys_clk); #1;
      a_valid = 1'b1; a_data = 8'h00; a_last = 1'b1; exp_q.push_back(8'h00);
      wait_ready(1'b0, 5, t);
      n_checks++; if (t < 0) begin n_fail++; $display("FAIL midreset_restart: a_ready not seen, required within 5 cycles"); end
      @(posedge sys_clk); #1; a_valid = 1'b0;
      wait_idle(60, t);
   endtask

   task automatic test_back_to_back();
      int t[3];
      logic [7:0] bytes[3];
      bytes[0] = 8'h3C; bytes[1] = 8'h5A; bytes[2] = 8'h96;
      @(posedge sys_clk); #1;
      a_valid = 1'b1; a_last = 1'b1; a_data = bytes[0];
      for (int i = 0; i < 3; i++) exp_q.push_back(bytes[i]);
      for (int i = 0; i < 3; i++) begin
         wait_ready(1'b0, 60, t[i]);
         n_checks++; if (t[i] < 0) begin n_fail++; $display("FAIL b2b_ready%0d: a_ready not seen, required within 60 cycles", i); end
         @(posedge sys_clk); #1;
         if (i < 2) a_data = bytes[i + 1];
         else a_valid = 1'b0;
      end
      n_checks++; if (t[1] - t[0] != 41) begin n_fail++; $display("FAIL b2b_gap01: got %0d cycles required 41", t[1] - t[0]); end
      n_checks++; if (t[2] - t[1] != 41) begin n_fail++; $display("FAIL b2b_gap12: got %0d cycles required 41", t[2] - t[1]); end
      wait_idle(60, t[0]);
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_lock();
      test_lock_timeout();
      test_reset_mid();
      test_back_to_back();
      repeat (5) @(negedge sys_clk);
      n_checks++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL frames_outstanding: %0d bytes never sent, required 0", exp_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
